// File: rtl/step_pulse_gen_if.sv
// Segment command channel from the UART command parser into one step/dir axis.
interface step_pulse_gen_if #(
    parameter int DIV_W = 15,
    parameter int CNT_W = 14
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [DIV_W-1:0] cmd_divider;
    logic [CNT_W-1:0] cmd_steps;
    logic             cmd_dir;

    modport master (output cmd_valid, cmd_divider, cmd_steps, cmd_dir, input cmd_ready);
    modport slave  (input cmd_valid, cmd_divider, cmd_steps, cmd_dir, output cmd_ready);
endinterface

// File: rtl/step_pulse_gen.sv
// Per-axis STEP/DIR pulse generator with a one-deep pending segment slot so
// consecutive same-direction segments chain without a gap.
module step_pulse_gen #(
    parameter int DIV_W     = 15,
    parameter int CNT_W     = 14,
    parameter int POS_W     = 20,
    parameter int PULSE_W   = 48,
    parameter int DIR_SETUP = 24
) (
    input  logic                    CLK,
    input  logic                    rst_n,
    step_pulse_gen_if.slave         cmd,
    input  logic                    abort,
    output logic                    step,
    output logic                    dir,
    output logic                    active,
    output logic                    seg_done,
    output logic signed [POS_W-1:0] pos
);

    typedef enum logic [1:0] {IDLE, SETUP, RUN} stateT;

    localparam logic [DIV_W-1:0] MIN_PERIOD = DIV_W'(2 * PULSE_W);
    localparam logic [DIV_W-1:0] PULSE_LIM  = DIV_W'(PULSE_W);
    localparam logic [DIV_W-1:0] SETUP_LOAD = DIV_W'(DIR_SETUP - 1);

    stateT            state;
    logic             pendValid;
    logic [DIV_W-1:0] pendDiv;
    logic [CNT_W-1:0] pendSteps;
    logic             pendDir;
    logic [DIV_W-1:0] period;
    logic [DIV_W-1:0] cnt;
    logic [CNT_W-1:0] stepsLeft;
    logic             segDir;
    logic             xfer;
    logic [DIV_W-1:0] pendPeriod;

    assign cmd.cmd_ready = ~pendValid;
    assign xfer          = cmd.cmd_valid & ~pendValid;
    assign pendPeriod    = (pendDiv < MIN_PERIOD) ? MIN_PERIOD : pendDiv;

    // segDir is the direction of the loaded segment; the dir pin follows it
    // on the first SETUP cycle so the driver sees exactly DIR_SETUP clocks.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pendValid <= 1'b0;
            pendDiv   <= '0;
            pendSteps <= '0;
            pendDir   <= 1'b0;
            period    <= '0;
            cnt       <= '0;
            stepsLeft <= '0;
            segDir    <= 1'b0;
            step      <= 1'b0;
            dir       <= 1'b0;
            active    <= 1'b0;
            seg_done  <= 1'b0;
            pos       <= '0;
        end else if (abort) begin
            state     <= IDLE;
            pendValid <= 1'b0;
            segDir    <= dir;
            step      <= 1'b0;
            active    <= 1'b0;
            seg_done  <= 1'b0;
        end else begin
            seg_done <= 1'b0;
            step     <= 1'b0;
            if (xfer) begin
                pendValid <= 1'b1;
                pendDiv   <= cmd.cmd_divider;
                pendSteps <= cmd.cmd_steps;
                pendDir   <= cmd.cmd_dir;
            end
            case (state)
                IDLE: begin
                    if (pendValid) begin
                        pendValid <= 1'b0;
                        if (pendSteps == '0) begin
                            seg_done <= 1'b1;
                        end else begin
                            period    <= pendPeriod;
                            stepsLeft <= pendSteps;
                            segDir    <= pendDir;
                            active    <= 1'b1;
                            if (pendDir != segDir) begin
                                state <= SETUP;
                                cnt   <= SETUP_LOAD;
                            end else begin
                                state <= RUN;
                                cnt   <= '0;
                            end
                        end
                    end
                end
                SETUP: begin
                    dir <= segDir;
                    if (cnt == '0) begin
                        state <= RUN;
                    end else begin
                        cnt <= cnt - DIV_W'(1);
                    end
                end
                RUN: begin
                    step <= (cnt < PULSE_LIM);
                    if (cnt == '0) begin
                        pos <= segDir ? pos + POS_W'(1) : pos - POS_W'(1);
                    end
                    // A zero-step pending segment is left in the slot for IDLE to retire.
                    if (cnt == period - DIV_W'(1)) begin
                        cnt <= '0;
                        if (stepsLeft == CNT_W'(1)) begin
                            seg_done <= 1'b1;
                            if (pendValid && pendSteps != '0) begin
                                pendValid <= 1'b0;
                                period    <= pendPeriod;
                                stepsLeft <= pendSteps;
                                segDir    <= pendDir;
                                if (pendDir != segDir) begin
                                    state <= SETUP;
                                    cnt   <= SETUP_LOAD;
                                end
                            end else begin
                                state  <= IDLE;
                                active <= 1'b0;
                            end
                        end else begin
                            stepsLeft <= stepsLeft - CNT_W'(1);
                        end
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Directed bench for step_pulse_gen: timing of STEP/DIR, chaining, clamping,
// direction setup, zero-step segments, abort and asynchronous reset.
module tb_step_pulse_gen;

    logic               CLK;
    logic               rst_n;
    logic               abort;
    logic               step;
    logic               dir;
    logic               active;
    logic               seg_done;
    logic signed [19:0] pos;

    int vectors    = 0;
    int miscompares = 0;

    int cyc       = 0;
    int lastRise  = 0;
    logic stepQ   = 1'b0;
    int rises[$];
    int highs[$];
    int doneCount = 0;

    step_pulse_gen_if #(.DIV_W(15), .CNT_W(14)) bus ();

    step_pulse_gen dut (
        .CLK      (CLK),
        .rst_n    (rst_n),
        .cmd      (bus),
        .abort    (abort),
        .step     (step),
        .dir      (dir),
        .active   (active),
        .seg_done (seg_done),
        .pos      (pos)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Records STEP rising-edge times, high widths and seg_done pulses.
    always @(negedge CLK) begin
        cyc = cyc + 1;
        if (step && !stepQ) begin
            rises.push_back(cyc);
            lastRise = cyc;
        end
        if (!step && stepQ) highs.push_back(cyc - lastRise);
        if (seg_done) doneCount = doneCount + 1;
        stepQ = step;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [14:0] div, input logic [13:0] steps, input logic d);
        bus.cmd_valid   = 1'b1;
        bus.cmd_divider = div;
        bus.cmd_steps   = steps;
        bus.cmd_dir     = d;
        @(negedge CLK);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic clearMonitor();
        rises.delete();
        highs.delete();
        doneCount = 0;
    endtask

    function automatic int spacing(input int idx);
        if (rises.size() > idx) return rises[idx] - rises[idx-1];
        return -1;
    endfunction

    task automatic checkHighs(input string tag);
        foreach (highs[i]) checkOutput(tag, highs[i], 48);
    endtask

    initial begin
        rst_n           = 1'b1;
        abort           = 1'b0;
        bus.cmd_valid   = 1'b0;
        bus.cmd_divider = '0;
        bus.cmd_steps   = '0;
        bus.cmd_dir     = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge CLK);
        checkOutput("rst step", step, 0);
        checkOutput("rst dir", dir, 0);
        checkOutput("rst active", active, 0);
        checkOutput("rst seg_done", seg_done, 0);
        checkOutput("rst pos", int'(pos), 0);
        checkOutput("rst cmd_ready", bus.cmd_ready, 1);
        rst_n = 1'b1;
        waitCycles(2);

        // Basic segment from reset: dir 0 -> 1 so a setup interval precedes the first step.
        clearMonitor();
        applyStimulus(15'd200, 14'd3, 1'b1);
        checkOutput("t1 cmd_ready busy", bus.cmd_ready, 0);
        waitCycles(1);
        checkOutput("t1 dir before toggle", dir, 0);
        checkOutput("t1 active", active, 1);
        checkOutput("t1 cmd_ready freed", bus.cmd_ready, 1);
        waitCycles(1);
        checkOutput("t1 dir toggled", dir, 1);
        checkOutput("t1 step in setup", step, 0);
        waitCycles(23);
        checkOutput("t1 step before rise", step, 0);
        waitCycles(1);
        checkOutput("t1 first rise", step, 1);
        checkOutput("t1 pos first", int'(pos), 1);
        waitCycles(598);
        checkOutput("t1 active last cycle", active, 1);
        checkOutput("t1 seg_done early", seg_done, 0);
        waitCycles(1);
        checkOutput("t1 seg_done", seg_done, 1);
        checkOutput("t1 active fall", active, 0);
        checkOutput("t1 pos end", int'(pos), 3);
        waitCycles(1);
        checkOutput("t1 seg_done one cycle", seg_done, 0);
        checkOutput("t1 rises", rises.size(), 3);
        checkOutput("t1 spacing 1", spacing(1), 200);
        checkOutput("t1 spacing 2", spacing(2), 200);
        checkOutput("t1 highs count", highs.size(), 3);
        checkHighs("t1 high width");
        checkOutput("t1 done count", doneCount, 1);

        // Divider below 2*PULSE_W is clamped to 96; same dir so step at N+2.
        clearMonitor();
        applyStimulus(15'd10, 14'd2, 1'b1);
        waitCycles(1);
        checkOutput("t2 step pre", step, 0);
        checkOutput("t2 active", active, 1);
        waitCycles(1);
        checkOutput("t2 first rise", step, 1);
        checkOutput("t2 pos first", int'(pos), 4);
        waitCycles(191);
        checkOutput("t2 seg_done", seg_done, 1);
        checkOutput("t2 active fall", active, 0);
        checkOutput("t2 pos end", int'(pos), 5);
        waitCycles(2);
        checkOutput("t2 rises", rises.size(), 2);
        checkOutput("t2 spacing", spacing(1), 96);
        checkHighs("t2 high width");
        checkOutput("t2 done count", doneCount, 1);

        // Chaining: B queued while A runs, seamless handover at A's last period.
        clearMonitor();
        applyStimulus(15'd300, 14'd2, 1'b1);
        waitCycles(10);
        applyStimulus(15'd150, 14'd4, 1'b1);
        checkOutput("t3 cmd_ready after queue", bus.cmd_ready, 0);
        waitCycles(589);
        checkOutput("t3 cmd_ready held", bus.cmd_ready, 0);
        checkOutput("t3 seg_done early", seg_done, 0);
        waitCycles(1);
        checkOutput("t3 seg_done A", seg_done, 1);
        checkOutput("t3 active across chain", active, 1);
        checkOutput("t3 cmd_ready after load", bus.cmd_ready, 1);
        waitCycles(1);
        checkOutput("t3 B first rise", step, 1);
        checkOutput("t3 pos mid", int'(pos), 8);
        waitCycles(599);
        checkOutput("t3 seg_done B", seg_done, 1);
        checkOutput("t3 active fall", active, 0);
        checkOutput("t3 pos end", int'(pos), 11);
        waitCycles(2);
        checkOutput("t3 rises", rises.size(), 6);
        checkOutput("t3 spacing A", spacing(1), 300);
        checkOutput("t3 spacing boundary", spacing(2), 300);
        checkOutput("t3 spacing B", spacing(3), 150);
        checkOutput("t3 spacing B last", spacing(5), 150);
        checkOutput("t3 done count", doneCount, 2);

        // Direction change back to negative.
        clearMonitor();
        applyStimulus(15'd200, 14'd5, 1'b0);
        waitCycles(1);
        checkOutput("t4 dir held", dir, 1);
        waitCycles(1);
        checkOutput("t4 dir toggled", dir, 0);
        waitCycles(23);
        checkOutput("t4 step before rise", step, 0);
        waitCycles(1);
        checkOutput("t4 first rise", step, 1);
        checkOutput("t4 pos first", int'(pos), 10);
        waitCycles(999);
        checkOutput("t4 seg_done", seg_done, 1);
        checkOutput("t4 active fall", active, 0);
        checkOutput("t4 pos end", int'(pos), 6);
        waitCycles(2);
        checkOutput("t4 rises", rises.size(), 5);
        checkOutput("t4 spacing", spacing(4), 200);
        checkOutput("t4 done count", doneCount, 1);

        // Zero-step segment retires immediately.
        clearMonitor();
        applyStimulus(15'd200, 14'd0, 1'b0);
        checkOutput("t5 cmd_ready busy", bus.cmd_ready, 0);
        waitCycles(1);
        checkOutput("t5 seg_done", seg_done, 1);
        checkOutput("t5 active", active, 0);
        waitCycles(1);
        checkOutput("t5 seg_done one cycle", seg_done, 0);
        waitCycles(5);
        checkOutput("t5 no steps", rises.size(), 0);
        checkOutput("t5 pos", int'(pos), 6);

        // Back-pressure and abort during a STEP high with the slot full.
        clearMonitor();
        applyStimulus(15'd200, 14'd100, 1'b0);
        bus.cmd_valid   = 1'b1;
        bus.cmd_divider = 15'd120;
        bus.cmd_steps   = 14'd3;
        bus.cmd_dir     = 1'b0;
        waitCycles(1);
        checkOutput("t6 cmd_ready open", bus.cmd_ready, 1);
        waitCycles(1);
        checkOutput("t6 cmd_ready full", bus.cmd_ready, 0);
        checkOutput("t6 step high", step, 1);
        checkOutput("t6 pos", int'(pos), 5);
        waitCycles(8);
        checkOutput("t6 back-pressure", bus.cmd_ready, 0);
        checkOutput("t6 still high", step, 1);
        abort = 1'b1;
        waitCycles(1);
        checkOutput("t6 abort step", step, 0);
        checkOutput("t6 abort active", active, 0);
        checkOutput("t6 abort cmd_ready", bus.cmd_ready, 1);
        checkOutput("t6 abort seg_done", seg_done, 0);
        checkOutput("t6 abort pos", int'(pos), 5);
        checkOutput("t6 abort dir", dir, 0);
        waitCycles(1);
        checkOutput("t6 discarded transfer", bus.cmd_ready, 1);
        abort         = 1'b0;
        bus.cmd_valid = 1'b0;
        waitCycles(10);
        checkOutput("t6 stays idle", active, 0);
        checkOutput("t6 rises", rises.size(), 1);
        checkOutput("t6 pos held", int'(pos), 5);
        checkOutput("t6 done count", doneCount, 0);

        // Asynchronous reset in the middle of a STEP pulse.
        applyStimulus(15'd200, 14'd5, 1'b1);
        waitCycles(30);
        checkOutput("t7 step high", step, 1);
        checkOutput("t7 dir", dir, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t7 rst step", step, 0);
        checkOutput("t7 rst dir", dir, 0);
        checkOutput("t7 rst active", active, 0);
        checkOutput("t7 rst pos", int'(pos), 0);
        checkOutput("t7 rst cmd_ready", bus.cmd_ready, 1);
        checkOutput("t7 rst seg_done", seg_done, 0);
        @(negedge CLK);
        rst_n = 1'b1;
        waitCycles(3);
        checkOutput("t7 idle after reset", active, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
